uart_tx_engine: RTL and testbench

Parametrised UART transmit engine that replaces the separate TX controller, serializer and parity blocks with one self-contained unit. It accepts a parallel word on a single-cycle valid, then drives a complete serial frame on `TX_OUT`: start bit, `DATA_W` data bits LSB-first, optional even/odd parity, and one or two stop bits. An internal prescaler sets each bit to `PRESCALE` clock cycles. It sits between the TX data source and the line driver.

---
 rtl/uart_tx_engine_if.sv | 24 ++
 rtl/uart_tx_engine.sv | 159 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// Parallel-in / serial-out handshake bundle for the UART transmit engine.
// The data source sits on the master side and the engine sits on the slave side.
interface uart_tx_engine_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              STOP2;
  logic              TX_OUT;
  logic              busy;
  logic              done;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    input  TX_OUT, busy, done
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    output TX_OUT, busy, done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_W data bits LSB-first, optional parity,
// one or two stop bits, each bit held for PRESCALE clk cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for Data_Valid
// S_START  | start bit (low)
// S_DATA   | data bits from shift_q[0], LSB first
// S_PARITY | parity over the latched word (even or odd)
// S_STOP   | one or two stop bits (high); last cycle may launch next frame
module uart_tx_engine #(
  parameter int DATA_W   = 8,
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_engine_if.slave   tx_if
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PS_W-1:0]     ps_cnt_q, ps_cnt_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_acc_q, par_acc_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic                launch;

  assign bit_end = (ps_cnt_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ps_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_cnt_q   <= ps_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ps_cnt_d   = ps_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    launch     = 1'b0;

    if (state_q != S_IDLE) begin
      ps_cnt_d = bit_end ? '0 : ps_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE:   launch = tx_if.Data_Valid;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        // parity accumulates as bits leave the shifter, so the word need not be kept
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          par_acc_d = par_acc_q ^ shift_q[0];
          if (bit_cnt_q == BC_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            state_d = S_IDLE;
            launch  = tx_if.Data_Valid;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        ps_cnt_d = '0;
      end
    endcase

    // the done cycle may chain straight into the next frame's start bit
    if (launch) begin
      state_d    = S_START;
      ps_cnt_d   = '0;
      bit_cnt_d  = '0;
      stop_idx_d = 1'b0;
      shift_d    = tx_if.P_DATA;
      par_acc_d  = 1'b0;
      par_en_d   = tx_if.PAR_EN;
      par_typ_d  = tx_if.PAR_TYP;
      stop2_d    = tx_if.STOP2;
    end
  end

  // outputs are decoded from the next state so the registered line lines up with it
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_acc_d ^ par_typ_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (stop_idx_d == stop2_d) && (ps_cnt_d == PS_LAST);
  end

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.busy   = busy_q;
  assign tx_if.done   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench: expected line waveform built per frame from the bit list
// (start, data LSB-first, parity, stops), each bit repeated P cycles.
module tb_uart_tx_engine;
  localparam int DW = 8;
  localparam int P  = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   fid = 0;
  bit   exp_tx[$];
  bit   exp_done[$];

  uart_tx_engine_if #(.DATA_W(DW)) tx_if ();

  uart_tx_engine #(.DATA_W(DW), .PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout sim did not finish checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(bit'(($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int r = 0; r < P; r++) begin
        exp_tx.push_back(bits[b]);
        exp_done.push_back(1'b0);
      end
    end
    exp_done[exp_done.size()-1] = 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, " tx"},   tx_if.TX_OUT, 1);
    check_eq({tag, " busy"}, tx_if.busy,   0);
    check_eq({tag, " done"}, tx_if.done,   0);
  endtask

  task automatic check_cycle(input int c);
    check_eq($sformatf("tx f%0d c%0d", fid, c+1),   tx_if.TX_OUT, exp_tx[c]);
    check_eq($sformatf("busy f%0d c%0d", fid, c+1), tx_if.busy,   1);
    check_eq($sformatf("done f%0d c%0d", fid, c+1), tx_if.done,   exp_done[c]);
  endtask

  task automatic abort_reset();
    #2 rst_n = 1'b0;
    #1;
    check_idle($sformatf("async_rst f%0d", fid));
    tx_if.Data_Valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle($sformatf("post_rst f%0d i%0d", fid, i));
    end
  endtask

  task automatic frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                       input bit disturb, input int abort_at);
    int n;
    exp_tx.delete();
    exp_done.delete();
    add_frame(d, pe, pt, s2);
    n = exp_tx.size();
    @(negedge clk);
    tx_if.P_DATA = d; tx_if.PAR_EN = pe; tx_if.PAR_TYP = pt; tx_if.STOP2 = s2;
    tx_if.Data_Valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (disturb && c < n-1) begin
        tx_if.Data_Valid = 1'($urandom_range(0, 1));
        tx_if.P_DATA     = DW'($urandom);
        tx_if.PAR_EN     = 1'($urandom_range(0, 1));
        tx_if.PAR_TYP    = 1'($urandom_range(0, 1));
        tx_if.STOP2      = 1'($urandom_range(0, 1));
      end else begin
        tx_if.Data_Valid = 1'b0;
      end
      if (c == abort_at) begin
        abort_reset();
        fid++;
        return;
      end
    end
    @(negedge clk);
    check_idle($sformatf("end f%0d", fid));
    fid++;
  endtask

  task automatic back_to_back();
    int n1, n;
    exp_tx.delete();
    exp_done.delete();
    add_frame(8'h3C, 0, 0, 0);
    n1 = exp_tx.size();
    add_frame(8'hC3, 0, 0, 0);
    n = exp_tx.size();
    @(negedge clk);
    tx_if.P_DATA = 8'h3C; tx_if.PAR_EN = 0; tx_if.PAR_TYP = 0; tx_if.STOP2 = 0;
    tx_if.Data_Valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (c == n1-1) tx_if.P_DATA = 8'hC3;
      if (c == n-1)  tx_if.Data_Valid = 1'b0;
    end
    @(negedge clk);
    check_idle($sformatf("end b2b f%0d", fid));
    fid++;
  endtask

  initial begin
    rst_n = 1'b0;
    tx_if.P_DATA = '0; tx_if.Data_Valid = 1'b0;
    tx_if.PAR_EN = 1'b0; tx_if.PAR_TYP = 1'b0; tx_if.STOP2 = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");

    frame(8'hA5, 0, 0, 0, 0, -1);
    frame(8'hA5, 1, 0, 0, 0, -1);
    frame(8'hA5, 1, 1, 0, 0, -1);
    frame(8'h00, 1, 1, 1, 0, -1);
    back_to_back();
    frame(8'h5A, 1, 0, 1, 1, -1);
    frame(8'hA5, 0, 0, 0, 0, 4*P + 1);
    frame(8'h96, 1, 0, 1, 0, -1);

    for (int k = 0; k < 12; k++) begin
      frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
